sram_arbiter: RTL
=================

# sram_arbiter

Shares the single asynchronous SRAM port between the instruction-fetch stage and the MEM stage, and sequences multi-cycle SRAM read/write timing. It generates the fetch stall that feeds the IF stage's bubble input (OR'd with hazard stalls outside this block). It returns fetched instructions and load data, and acknowledges every MEM access.

## Interface
- `ADDR_W`, default 20: SRAM word-address width; SRAM address = byte address [ADDR_W+1:2].
- `RD_CYCLES`, default 2: cycles the SRAM read controls are held before data is sampled (≥1).
- `WE_CYCLES`, default 1: cycles `sram_we_n` is held low during a write (≥1).
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `if_addr`  in  32: fetch byte address (IF program counter), stable while `if_stall`=1.
- `if_data`  out  32: fetched instruction, valid only while `if_stall`=0.
- `if_stall`  out  1: 1 = fetch not complete this cycle; IF must not advance.
- `mem_req`  in  1: MEM access request, held until `mem_ack`.
- `mem_we`  in  1: 1 = write, 0 = read.
- `mem_be`  in  4: active-high byte enables for writes.
- `mem_addr`  in  32: data byte address.
- `mem_wdata`  in  32: store data.
- `mem_rdata`  out  32: load word, valid while `mem_ack`=1.
- `mem_ack`  out  1: one-cycle completion pulse.
- `sram_addr`  out  ADDR_W: SRAM word address.
- `sram_dq_o`  out  32: write data to pad.
- `sram_dq_oe`  out  1: pad output enable.
- `sram_dq_i`  in  32: read data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each: active-low strobes.
- `sram_be_n`  out  4: active-low byte enables.

## Operation
- Fetch is always requested; there is no fetch-request input.
- States: IDLE, IF_RD, IF_RESP, MEM_RD, MEM_RESP, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration happens on the clock edge leaving IDLE, IF_RESP or MEM_RESP (the free states):
  - `mem_req`=0: go to IF_RD.
  - `mem_req`=1 and the last grant was IF: go to MEM_RD (`mem_we`=0) or WR_SETUP (`mem_we`=1).
  - `mem_req`=1 and the last grant was MEM: go to IF_RD (round-robin, so IF is never starved).
  - `last_grant` is registered; its reset value is IF.
- Address, write data and byte enables are latched at the grant edge and held for the whole access.
- IF_RD / MEM_RD:
  - Outputs: `ce_n`=0, `oe_n`=0, `be_n`=0000, `dq_oe`=0.
  - Stay RD_CYCLES cycles (down-counter), sample `sram_dq_i` into a register on the last edge, then go to the matching RESP state.
- IF_RESP:
  - `if_stall`=0 and `if_data` = sampled word.
  - Register keeps `if_data` stable after IF_RESP; otherwise `if_stall`=1 in every state.
- MEM_RESP: `mem_ack`=1 and `mem_rdata` = sampled word (reads) or don't-care (writes).
- Write sequence:
  - WR_SETUP, 1 cycle: `ce_n`=0, `we_n`=1, `dq_oe`=1, `be_n`=~`mem_be`.
  - WR_PULSE, WE_CYCLES cycles: same as setup but `we_n`=0.
  - WR_HOLD, 1 cycle: `we_n`=1, `dq_oe`=1, `ce_n`=0.
  - Then MEM_RESP.
- `oe_n`=1 during all write states; `oe_n` and `dq_oe` are never both active.
- `mem_be`=0000 on a write still runs the full sequence with `be_n`=1111 and acks.
- A `mem_req` that drops before ack is a protocol violation; the latched access completes anyway.

## Timing
- Reset (async, any state): state IDLE, `last_grant`=IF, counter 0; `if_stall`=1, `mem_ack`=0, `if_data`=0, `mem_rdata`=0; `sram_addr`=0, `sram_dq_o`=0, `dq_oe`=0, `ce_n`=`oe_n`=`we_n`=1, `be_n`=1111.
- Reset asserted mid-write forces `we_n` high immediately; the write is lost.
- Fetch latency: grant edge, then RD_CYCLES cycles in IF_RD, then 1 cycle in IF_RESP. Back-to-back fetches run at 1 word per RD_CYCLES+1 cycles.
- MEM read: RD_CYCLES+1 cycles from grant to the ack cycle.
- MEM write: WE_CYCLES+3 cycles from grant to the ack cycle.
- Simultaneous `mem_req` rise in IF_RESP: IF completes this cycle and MEM is granted next (`last_grant`=IF).
- All SRAM outputs are registered (glitch-free strobes).

## Structure
- Shared package `sram_pkg`: state enum; `GRANT_IF`/`GRANT_MEM` constants; default `RD_CYCLES`/`WE_CYCLES`.
- Single module; the cycle counter is inline, no sub-module.

## Test plan
- Reset release with no `mem_req`, `if_addr`=0x80001180:
  - `sram_addr`=0x00460 from cycle 1.
  - `if_stall`=0 exactly in cycle 3 (RD_CYCLES=2) with `if_data`=model[0x460].
  - Repeats every 3 cycles.
- `mem_req` read to 0x80400004 asserted during IF_RD: IF completes first, then MEM_RD, then `mem_ack` one cycle with `mem_rdata`=model word; `if_stall`=1 throughout.
- Write 0xDEADBEEF, `mem_be`=0011, addr 0x80000008:
  - `be_n`=1100; `we_n` low exactly 1 cycle.
  - `dq_oe`=1 from setup through hold; ack at grant+4.
  - Readback returns only the low half updated.
- `mem_req` held continuously for 10 accesses: grants alternate IF, MEM, IF, …; no two consecutive MEM grants.
- Async reset asserted in WR_PULSE: `we_n`, `ce_n`, `dq_oe` return to inactive within the same cycle; FSM restarts with a fetch.
- Assertion throughout all tests: never `oe_n`=0 with `dq_oe`=1; `mem_ack` never high for 2 consecutive cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and defaults for the IF/MEM SRAM port arbiter.
package sram_pkg;

  localparam int unsigned DEF_RD_CYCLES = 2;
  localparam int unsigned DEF_WE_CYCLES = 1;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_IF_RESP,
    ST_MEM_RD,
    ST_MEM_RESP,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between instruction fetch
// and the MEM stage, with registered strobes and multi-cycle read/write timing.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned RD_CYCLES = DEF_RD_CYCLES,
  parameter int unsigned WE_CYCLES = DEF_WE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int unsigned CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t              r_state, w_state_nx;
  logic                r_last_grant, w_last_grant_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0]   r_sram_addr, w_addr_nx;
  logic [31:0]         r_sram_dq_o, w_dq_o_nx;
  logic [3:0]          r_sram_be_n, w_be_n_nx;
  logic                r_sram_dq_oe, w_dq_oe_nx;
  logic                r_sram_ce_n, w_ce_n_nx;
  logic                r_sram_oe_n, w_oe_n_nx;
  logic                r_sram_we_n, w_we_n_nx;
  logic [31:0]         r_if_data, w_if_data_nx;
  logic [31:0]         r_mem_rdata, w_mem_rdata_nx;
  logic                r_if_stall, w_if_stall_nx;
  logic                r_mem_ack, w_mem_ack_nx;

  // Byte-offset and above-window address bits are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                      mem_addr[1:0], mem_addr[31:ADDR_W+2]};

  // Next-state, access latching and next values of the registered outputs.
  always_comb begin
    w_state_nx      = r_state;
    w_last_grant_nx = r_last_grant;
    w_cnt_nx        = r_cnt;
    w_addr_nx       = r_sram_addr;
    w_dq_o_nx       = r_sram_dq_o;
    w_be_n_nx       = r_sram_be_n;
    w_if_data_nx    = r_if_data;
    w_mem_rdata_nx  = r_mem_rdata;
    w_dq_oe_nx      = 1'b0;
    w_ce_n_nx       = 1'b1;
    w_oe_n_nx       = 1'b1;
    w_we_n_nx       = 1'b1;
    w_if_stall_nx   = 1'b1;
    w_mem_ack_nx    = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_IF_RESP, ST_MEM_RESP: begin
        w_cnt_nx = CNT_W'(RD_CYCLES - 1);
        if (mem_req && (r_last_grant == GRANT_IF)) begin
          w_last_grant_nx = GRANT_MEM;
          w_addr_nx       = mem_addr[ADDR_W+1:2];
          if (mem_we) begin
            w_state_nx = ST_WR_SETUP;
            w_dq_o_nx  = mem_wdata;
            w_be_n_nx  = ~mem_be;
          end else begin
            w_state_nx = ST_MEM_RD;
            w_be_n_nx  = 4'h0;
          end
        end else begin
          w_last_grant_nx = GRANT_IF;
          w_state_nx      = ST_IF_RD;
          w_addr_nx       = if_addr[ADDR_W+1:2];
          w_be_n_nx       = 4'h0;
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        if (r_cnt == '0) begin
          if (r_state == ST_IF_RD) begin
            w_state_nx   = ST_IF_RESP;
            w_if_data_nx = sram_dq_i;
          end else begin
            w_state_nx     = ST_MEM_RESP;
            w_mem_rdata_nx = sram_dq_i;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        w_state_nx = ST_WR_PULSE;
        w_cnt_nx   = CNT_W'(WE_CYCLES - 1);
      end
      ST_WR_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_WR_HOLD;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        w_state_nx = ST_MEM_RESP;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they leave a flop cleanly.
    unique case (w_state_nx)
      ST_IF_RD, ST_MEM_RD: begin
        w_ce_n_nx = 1'b0;
        w_oe_n_nx = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        w_ce_n_nx  = 1'b0;
        w_dq_oe_nx = 1'b1;
      end
      ST_WR_PULSE: begin
        w_ce_n_nx  = 1'b0;
        w_we_n_nx  = 1'b0;
        w_dq_oe_nx = 1'b1;
      end
      ST_IF_RESP: begin
        w_if_stall_nx = 1'b0;
        w_be_n_nx     = 4'hF;
      end
      ST_MEM_RESP: begin
        w_mem_ack_nx = 1'b1;
        w_be_n_nx    = 4'hF;
      end
      default: begin
        w_be_n_nx = 4'hF;
      end
    endcase
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_IF;
      r_cnt        <= '0;
      r_sram_addr  <= '0;
      r_sram_dq_o  <= '0;
      r_sram_be_n  <= 4'hF;
      r_sram_dq_oe <= 1'b0;
      r_sram_ce_n  <= 1'b1;
      r_sram_oe_n  <= 1'b1;
      r_sram_we_n  <= 1'b1;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
      r_if_stall   <= 1'b1;
      r_mem_ack    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_last_grant <= w_last_grant_nx;
      r_cnt        <= w_cnt_nx;
      r_sram_addr  <= w_addr_nx;
      r_sram_dq_o  <= w_dq_o_nx;
      r_sram_be_n  <= w_be_n_nx;
      r_sram_dq_oe <= w_dq_oe_nx;
      r_sram_ce_n  <= w_ce_n_nx;
      r_sram_oe_n  <= w_oe_n_nx;
      r_sram_we_n  <= w_we_n_nx;
      r_if_data    <= w_if_data_nx;
      r_mem_rdata  <= w_mem_rdata_nx;
      r_if_stall   <= w_if_stall_nx;
      r_mem_ack    <= w_mem_ack_nx;
    end
  end

  assign if_data    = r_if_data;
  assign if_stall   = r_if_stall;
  assign mem_rdata  = r_mem_rdata;
  assign mem_ack    = r_mem_ack;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_sram_dq_oe;
  assign sram_ce_n  = r_sram_ce_n;
  assign sram_oe_n  = r_sram_oe_n;
  assign sram_we_n  = r_sram_we_n;
  assign sram_be_n  = r_sram_be_n;

endmodule
